// File: rtl/uart_rx_deser_if.sv
// Received-byte bus between the UART RX deserialiser and the APB UART top.
// The deserialiser drives every signal; the consumer only observes them.
interface uart_rx_deser_if;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_err_o;
    logic       rx_frame_err_o;
    logic       busy_o;

    modport master (
        output rx_data_o,
        output rx_valid_o,
        output rx_err_o,
        output rx_frame_err_o,
        output busy_o
    );

    modport slave (
        input rx_data_o,
        input rx_valid_o,
        input rx_err_o,
        input rx_frame_err_o,
        input busy_o
    );
endinterface

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: synchronises rx_i, detects start edges, samples
// each bit at mid-period with a divider latched at the start of the frame,
// checks parity and stop bit, and delivers one byte per frame as a
// single-cycle valid pulse.
module uart_rx_deser #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 1,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic [31:0]          clk_div_i,
    input  logic                 rx_enable_i,
    input  logic                 rx_i,
    uart_rx_deser_if.master      rx_bus
);

    localparam bit HAS_PAR = (PARITY_EN != 0);
    localparam bit PAR_ODD = (PARITY_ODD != 0);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    // Divider saturation: a bit period shorter than 2 clocks cannot be
    // mid-sampled, so small or zero settings are clamped up to 2.
    function automatic logic [31:0] sat_div(input logic [31:0] d);
        return (d < 32'd2) ? 32'd2 : d;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line;
    logic                   prev_q;

    state_t                 state_q, state_d;
    logic [31:0]            timer_q, timer_d;
    logic [31:0]            div_q, div_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_err_q, par_err_d;
    logic [7:0]             data_d;
    logic                   valid_d, err_d, ferr_d;
    logic                   expire;

    assign line   = sync_q[SYNC_STAGES-1];
    assign expire = (timer_q <= 32'd1);
    assign rx_bus.busy_o = (state_q != IDLE);

    // Metastability synchroniser for the asynchronous rx pin, idling high.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            prev_q <= line;
        end
    end

    // Frame sequencing: next state, bit timer, shift register and outputs.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        data_d    = rx_bus.rx_data_o;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a genuine 1->0 edge starts a frame; a line already
                // low when enable rises is ignored.
                if (rx_enable_i && prev_q && !line) begin
                    state_d   = START;
                    div_d     = sat_div(clk_div_i);
                    timer_d   = sat_div(clk_div_i) >> 1;
                    cnt_d     = '0;
                    shift_d   = '0;
                    par_err_d = 1'b0;
                end
            end
            START: begin
                if (expire) begin
                    if (!line) begin
                        state_d = DATA;
                        timer_d = div_q;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            DATA: begin
                if (expire) begin
                    shift_d = {line, shift_q[DATA_BITS-1:1]};
                    timer_d = div_q;
                    if (cnt_q == LAST_BIT) begin
                        state_d = HAS_PAR ? PARITY : STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            PARITY: begin
                if (expire) begin
                    par_err_d = ((^shift_q) ^ line) != PAR_ODD;
                    state_d   = STOP;
                    timer_d   = div_q;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            STOP: begin
                if (expire) begin
                    valid_d = 1'b1;
                    data_d  = 8'(shift_q);
                    err_d   = par_err_q;
                    ferr_d  = !line;
                    state_d = line ? IDLE : BREAK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            BREAK: begin
                if (line) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Losing enable mid-frame discards the frame without a pulse.
        if (state_q != IDLE && !rx_enable_i) begin
            state_d   = IDLE;
            timer_d   = '0;
            cnt_d     = '0;
            shift_d   = '0;
            par_err_d = 1'b0;
            data_d    = rx_bus.rx_data_o;
            valid_d   = 1'b0;
            err_d     = 1'b0;
            ferr_d    = 1'b0;
        end
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q               <= IDLE;
            timer_q               <= '0;
            div_q                 <= '0;
            cnt_q                 <= '0;
            shift_q               <= '0;
            par_err_q             <= 1'b0;
            rx_bus.rx_data_o      <= '0;
            rx_bus.rx_valid_o     <= 1'b0;
            rx_bus.rx_err_o       <= 1'b0;
            rx_bus.rx_frame_err_o <= 1'b0;
        end else begin
            state_q               <= state_d;
            timer_q               <= timer_d;
            div_q                 <= div_d;
            cnt_q                 <= cnt_d;
            shift_q               <= shift_d;
            par_err_q             <= par_err_d;
            rx_bus.rx_data_o      <= data_d;
            rx_bus.rx_valid_o     <= valid_d;
            rx_bus.rx_err_o       <= err_d;
            rx_bus.rx_frame_err_o <= ferr_d;
        end
    end

endmodule
